// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller and its bus monitor.
// Segment codes are active-low, bit order gfedcba.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10,
        NONE   = 2'b11
    } phase_e;

    // Monitor FSM encoding matches phase_e so the state drives the phase output directly.
    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_SYNC   = 2'b11
    } mon_state_e;

    localparam int RED_SEC_DEF    = 18;
    localparam int GREEN_SEC_DEF  = 15;
    localparam int YELLOW_SEC_DEF = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0: seg_encode = SEG_0;
            4'd1: seg_encode = SEG_1;
            4'd2: seg_encode = SEG_2;
            4'd3: seg_encode = SEG_3;
            4'd4: seg_encode = SEG_4;
            4'd5: seg_encode = SEG_5;
            4'd6: seg_encode = SEG_6;
            4'd7: seg_encode = SEG_7;
            4'd8: seg_encode = SEG_8;
            4'd9: seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/traffic_monitor_seg7.sv
// Combinational decode of one active-low 7-segment digit back to its BCD value.
module seg7_digit_decode
    import traffic_pkg::*;
(
    input  logic [6:0] code,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (code)
            SEG_0: digit = 4'd0;
            SEG_1: digit = 4'd1;
            SEG_2: digit = 4'd2;
            SEG_3: digit = 4'd3;
            SEG_4: digit = 4'd4;
            SEG_5: digit = 4'd5;
            SEG_6: digit = 4'd6;
            SEG_7: digit = 4'd7;
            SEG_8: digit = 4'd8;
            SEG_9: digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_monitor.sv
// Passive checker for the traffic-light controller: decodes the countdown display,
// follows the lamp phase sequence and per-second timing, and raises sticky error flags.
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int TICK_CYCLES = 10000000,
    parameter int TOL_CYCLES  = 2,
    parameter int RED_SEC     = RED_SEC_DEF,
    parameter int GREEN_SEC   = GREEN_SEC_DEF,
    parameter int YELLOW_SEC  = YELLOW_SEC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        red_light,
    input  logic        yellow_light,
    input  logic        green_light,
    input  logic [15:0] display_led,
    input  logic        clr_err,
    output logic [1:0]  phase,
    output logic [5:0]  cur_value,
    output logic        phase_done,
    output logic        err_onehot,
    output logic        err_code,
    output logic        err_seq,
    output logic        err_count,
    output logic        err_timing,
    output logic        err_any
);

    localparam logic [26:0] T_MIN = 27'(TICK_CYCLES - TOL_CYCLES);
    localparam logic [26:0] T_MAX = 27'(TICK_CYCLES + TOL_CYCLES);

    logic        s_vld, s_en, s_clr;
    logic [2:0]  s_lamp;                    // {green, yellow, red}
    logic [15:0] s_disp;

    mon_state_e  state_q, state_d, lamp_st;
    logic [2:0]  p_lamp;
    logic [6:0]  p_val, dec_val, val_now;
    logic [25:0] sec_cnt;
    logic [26:0] elapsed;
    logic        stalled, stall_d, cnt_clr, done_d, t_bad, lamp_oh;
    logic [3:0]  ones, tens;
    logic        ones_ok, tens_ok, dig_ok;
    logic        set_oh, set_code, set_seq, set_cnt, set_tim;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_vld  <= 1'b0;
            s_en   <= 1'b0;
            s_clr  <= 1'b0;
            s_lamp <= 3'b000;
            s_disp <= 16'h0000;
        end else begin
            s_vld  <= 1'b1;
            s_en   <= en;
            s_clr  <= clr_err;
            s_lamp <= {green_light, yellow_light, red_light};
            s_disp <= display_led;
        end
    end

    seg7_digit_decode u_ones (.code(s_disp[6:0]),  .digit(ones), .valid(ones_ok));
    seg7_digit_decode u_tens (.code(s_disp[14:8]), .digit(tens), .valid(tens_ok));

    assign dig_ok  = ones_ok & tens_ok;
    assign dec_val = {3'b000, tens} * 7'd10 + {3'b000, ones};
    assign val_now = dig_ok ? dec_val : p_val;
    assign elapsed = {1'b0, sec_cnt} + 27'd1;
    assign t_bad   = (elapsed < T_MIN) | (elapsed > T_MAX);
    assign lamp_oh = (s_lamp == 3'b001) | (s_lamp == 3'b010) | (s_lamp == 3'b100);

    always_comb begin
        case (s_lamp)
            3'b010:  lamp_st = ST_YELLOW;
            3'b100:  lamp_st = ST_GREEN;
            default: lamp_st = ST_RED;
        endcase
    end

    function automatic mon_state_e succ(input mon_state_e st);
        case (st)
            ST_RED:   succ = ST_GREEN;
            ST_GREEN: succ = ST_YELLOW;
            default:  succ = ST_RED;
        endcase
    endfunction

    function automatic logic [6:0] start_val(input mon_state_e st);
        case (st)
            ST_GREEN:  start_val = 7'(GREEN_SEC);
            ST_YELLOW: start_val = 7'(YELLOW_SEC);
            default:   start_val = 7'(RED_SEC);
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        stall_d  = stalled;
        cnt_clr  = 1'b0;
        set_oh   = 1'b0;
        set_seq  = 1'b0;
        set_cnt  = 1'b0;
        set_tim  = 1'b0;
        set_code = s_vld & (~dig_ok | ~s_disp[7] | ~s_disp[15] | (dig_ok & (dec_val > 7'd63)));
        if (s_vld) begin
            if (!lamp_oh) begin
                set_oh = 1'b1;
            end else if (state_q == ST_SYNC) begin
                if (s_lamp != p_lamp) begin
                    state_d = lamp_st;
                    cnt_clr = 1'b1;
                    stall_d = 1'b0;
                end
            end else if (s_lamp == p_lamp) begin
                if (val_now == p_val) begin
                    // Report a stalled second once; re-armed by the next value change.
                    if (elapsed > T_MAX && !stalled) begin
                        set_tim = 1'b1;
                        stall_d = 1'b1;
                    end
                end else if (p_val != 7'd0 && val_now == p_val - 7'd1) begin
                    set_tim = t_bad & ~stalled;
                    cnt_clr = 1'b1;
                    stall_d = 1'b0;
                end else begin
                    // Re-anchor the second on the adopted value.
                    set_cnt = 1'b1;
                    cnt_clr = 1'b1;
                    stall_d = 1'b0;
                end
            end else if (lamp_st == succ(state_q)) begin
                done_d  = 1'b1;
                set_seq = (p_val != 7'd0) | (val_now != start_val(lamp_st));
                set_tim = t_bad & ~stalled;
                cnt_clr = 1'b1;
                stall_d = 1'b0;
                state_d = lamp_st;
            end else begin
                set_seq = 1'b1;
                cnt_clr = 1'b1;
                stall_d = 1'b0;
                state_d = lamp_st;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            p_lamp     <= 3'b000;
            p_val      <= 7'd0;
            sec_cnt    <= 26'd0;
            stalled    <= 1'b0;
            cur_value  <= 6'd0;
            phase_done <= 1'b0;
            err_onehot <= 1'b0;
            err_code   <= 1'b0;
            err_seq    <= 1'b0;
            err_count  <= 1'b0;
            err_timing <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_done <= done_d;
            stalled    <= stall_d;
            if (s_vld) begin
                p_val     <= val_now;
                cur_value <= (val_now > 7'd63) ? 6'd63 : val_now[5:0];
                if (lamp_oh) p_lamp <= s_lamp;
            end
            if (cnt_clr || state_q == ST_SYNC) sec_cnt <= 26'd0;
            else if (s_en && sec_cnt != '1)    sec_cnt <= sec_cnt + 26'd1;
            err_onehot <= (err_onehot & ~s_clr) | set_oh;
            err_code   <= (err_code   & ~s_clr) | set_code;
            err_seq    <= (err_seq    & ~s_clr) | set_seq;
            err_count  <= (err_count  & ~s_clr) | set_cnt;
            err_timing <= (err_timing & ~s_clr) | set_tim;
        end
    end

    assign phase   = state_q;
    assign err_any = err_onehot | err_code | err_seq | err_count | err_timing;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor with a cycle-level reference model and literal spot checks.
module tb_traffic_monitor;

    localparam int TICK = 10;
    localparam int TOL  = 2;
    localparam int TMIN = TICK - TOL;
    localparam int TMAX = TICK + TOL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        red_light = 1'b1, yellow_light = 1'b0, green_light = 1'b0;
    logic [15:0] display_led = 16'hFFFF;
    logic        clr_err = 1'b0;
    logic [1:0]  phase;
    logic [5:0]  cur_value;
    logic        phase_done, err_onehot, err_code, err_seq, err_count, err_timing, err_any;

    traffic_monitor #(.TICK_CYCLES(TICK), .TOL_CYCLES(TOL)) dut (
        .clk(clk), .rst(rst), .en(en),
        .red_light(red_light), .yellow_light(yellow_light), .green_light(green_light),
        .display_led(display_led), .clr_err(clr_err),
        .phase(phase), .cur_value(cur_value), .phase_done(phase_done),
        .err_onehot(err_onehot), .err_code(err_code), .err_seq(err_seq),
        .err_count(err_count), .err_timing(err_timing), .err_any(err_any)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int start_sec [3] = '{18, 15, 3};

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=red 1=green 2=yellow 3=unsynced; flags {timing,count,seq,code,onehot}
    typedef struct { int ph; int cur; bit done; bit [4:0] f; } exp_t;
    exp_t e_cur, e_pend;
    int   m_ph, m_lamp, m_val, m_cnt;
    bit   m_stall, m_live = 0;
    bit [4:0] m_flags;

    task automatic m_reset();
        m_ph = 3; m_lamp = -1; m_val = 0; m_cnt = 0; m_stall = 0; m_flags = '0;
        e_cur.ph = 3; e_cur.cur = 0; e_cur.done = 0; e_cur.f = '0;
        e_pend = e_cur;
    endtask

    task automatic m_step();
        int t, o, v, lp, el, ph0;
        bit ok, oh, chg;
        bit [4:0] s;
        t = -1; o = -1; s = '0; chg = 0; ph0 = m_ph;
        for (int i = 0; i < 10; i++) begin
            if (display_led[14:8] == seg_tab[i]) t = i;
            if (display_led[6:0]  == seg_tab[i]) o = i;
        end
        ok = (t >= 0) && (o >= 0);
        v  = ok ? t * 10 + o : m_val;
        s[1] = !ok || !display_led[7] || !display_led[15] || v > 63;
        oh = $countones({red_light, yellow_light, green_light}) == 1;
        lp = red_light ? 0 : (green_light ? 1 : 2);
        el = m_cnt + 1;
        e_pend.done = 0;
        if (!oh) s[0] = 1;
        else if (m_ph == 3) begin
            if (lp != m_lamp) begin m_ph = lp; chg = 1; end
        end else if (lp == m_lamp) begin
            if (v == m_val) begin
                if (el > TMAX && !m_stall) begin s[4] = 1; m_stall = 1; end
            end else if (v == m_val - 1) begin
                if (!m_stall && (el < TMIN || el > TMAX)) s[4] = 1;
                chg = 1;
            end else begin s[3] = 1; chg = 1; end
        end else if (lp == (m_ph + 1) % 3) begin
            e_pend.done = 1;
            if (m_val != 0 || v != start_sec[lp]) s[2] = 1;
            if (!m_stall && (el < TMIN || el > TMAX)) s[4] = 1;
            chg = 1; m_ph = lp;
        end else begin s[2] = 1; chg = 1; m_ph = lp; end
        if (chg) begin m_cnt = 0; m_stall = 0; end
        else if (ph0 != 3 && en) m_cnt++;
        m_flags = (m_flags & ~{5{clr_err}}) | s;
        if (oh) m_lamp = lp;
        m_val = v;
        e_pend.ph = m_ph;
        e_pend.cur = (v > 63) ? 63 : v;
        e_pend.f = m_flags;
    endtask

    always @(posedge clk) begin
        if (rst) begin m_reset(); m_live = 1; end
        else begin e_cur = e_pend; m_step(); end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("phase", int'(phase), e_cur.ph);
            chk("cur_value", int'(cur_value), e_cur.cur);
            chk("phase_done", int'(phase_done), int'(e_cur.done));
            chk("err_onehot", int'(err_onehot), int'(e_cur.f[0]));
            chk("err_code", int'(err_code), int'(e_cur.f[1]));
            chk("err_seq", int'(err_seq), int'(e_cur.f[2]));
            chk("err_count", int'(err_count), int'(e_cur.f[3]));
            chk("err_timing", int'(err_timing), int'(e_cur.f[4]));
            chk("err_any", int'(err_any), int'(|e_cur.f));
            if (phase_done) done_seen++;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_disp(input int v);
        display_led = {1'b1, seg_tab[v / 10], 1'b1, seg_tab[v % 10]};
    endtask

    task automatic set_lamp(input int ph);
        red_light = (ph == 0); green_light = (ph == 1); yellow_light = (ph == 2);
    endtask

    task automatic show(input int ph, input int v, input int n);
        set_lamp(ph); set_disp(v); hold(n);
    endtask

    // Same as show, with clr_err pulsed on the first sample.
    task automatic show_clr(input int ph, input int v, input int n);
        set_lamp(ph); set_disp(v); clr_err = 1'b1; hold(1); clr_err = 1'b0; hold(n - 1);
    endtask

    task automatic run(input int ph, input int from, input int to);
        for (int v = from; v >= to; v--) show(ph, v, 10);
    endtask

    initial begin
        set_lamp(0); set_disp(18);
        @(negedge clk); hold(2);
        rst = 1'b0; hold(1);
        chk("reset_phase", int'(phase), 3);
        chk("reset_cur", int'(cur_value), 0);
        chk("reset_err", int'(err_any), 0);

        // Full legal cycle
        show(0, 18, 9);
        run(0, 17, 0); run(1, 15, 0); run(2, 3, 0); show(0, 18, 10);
        chk("t1_done_pulses", done_seen, 3);
        chk("t1_err_any", int'(err_any), 0);
        chk("t1_phase", int'(phase), 0);
        chk("t1_cur", int'(cur_value), 18);

        // Short second
        show(0, 17, 7); show(0, 16, 4);
        chk("t2_timing", int'(err_timing), 1);
        chk("t2_seq", int'(err_seq), 0);
        chk("t2_count", int'(err_count), 0);
        show_clr(0, 16, 4);
        chk("t2_cleared", int'(err_any), 0);

        // Skipped state, then early exit from green
        show(2, 3, 4);
        chk("t3_seq_skip", int'(err_seq), 1);
        chk("t3_phase_y", int'(phase), 2);
        show_clr(2, 3, 4);
        show(1, 5, 2); show_clr(1, 5, 8);
        chk("t3_cleared", int'(err_any), 0);
        show(1, 4, 10); show(2, 3, 10);
        chk("t3_seq_early", int'(err_seq), 1);
        chk("t3_phase_y2", int'(phase), 2);
        chk("t3_timing", int'(err_timing), 0);

        // Lamp glitch and illegal segment code
        show_clr(2, 2, 3);
        red_light = 1'b1; green_light = 1'b1; yellow_light = 1'b0; hold(1);
        set_lamp(2); hold(1);
        display_led[6:0] = 7'b0110110; hold(3);
        chk("t4_cur_held", int'(cur_value), 2);
        chk("t4_onehot", int'(err_onehot), 1);
        chk("t4_code", int'(err_code), 1);
        set_disp(2); hold(2);
        chk("t4_seq", int'(err_seq), 0);
        chk("t4_count", int'(err_count), 0);
        chk("t4_timing", int'(err_timing), 0);
        show(2, 1, 10); show(2, 0, 10); show(0, 18, 10);

        // Count jump and set-dominant clear
        show_clr(0, 17, 10); run(0, 16, 12);
        chk("t5_clean", int'(err_any), 0);
        show(0, 10, 10);
        chk("t5_count", int'(err_count), 1);
        show_clr(0, 8, 10);
        chk("t5_set_dominant", int'(err_count), 1);

        // Clear alone, enable stall, value stall, reset
        show_clr(0, 7, 4);
        chk("t6_cleared", int'(err_any), 0);
        en = 1'b0; hold(50);
        chk("t6_en_stall", int'(err_timing), 0);
        en = 1'b1; hold(6);
        show(0, 6, 20);
        chk("t6_stall", int'(err_timing), 1);
        clr_err = 1'b1; hold(1); clr_err = 1'b0; hold(10);
        chk("t6_no_repeat", int'(err_timing), 0);
        show(0, 3, 3);
        chk("t6_count", int'(err_count), 1);
        rst = 1'b1; hold(1);
        chk("t6_rst_phase", int'(phase), 3);
        chk("t6_rst_err", int'(err_any), 0);
        chk("t6_rst_cur", int'(cur_value), 0);
        rst = 1'b0; hold(3);
        chk("t6_resync", int'(phase), 0);
        hold(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_monitor.md
Name: traffic_monitor

Overview:
- Passive receiver/checker for the traffic-light controller output interface.
- Samples the three lamp outputs and the 16-bit, 2-digit, active-low 7-segment bus, decodes the displayed countdown, and tracks phase sequence and timing.
- Sets sticky error flags on any protocol violation.
- Sits beside the controller on the board and in the system bench as a bus monitor. It drives nothing back into the controller.

Parameters:
- TICK_CYCLES, 10000000: expected clock cycles per displayed second; the bench uses 10.
- TOL_CYCLES, 2: allowed ± deviation in cycles per second.
- RED_SEC, 18: countdown start value for the red phase.
- GREEN_SEC, 15: countdown start value for the green phase.
- YELLOW_SEC, 3: countdown start value for the yellow phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  controller enable mirror; timing counter advances only when en=1.
- red_light  in  1  lamp input.
- yellow_light  in  1  lamp input.
- green_light  in  1  lamp input.
- display_led  in  16  [6:0]=ones segments, [14:8]=tens segments, [7],[15]=DP; all active-low.
- clr_err  in  1  one-cycle pulse; clears all sticky flags.
- phase  out  2  00=RED, 01=GREEN, 10=YELLOW, 11=unsynced.
- cur_value  out  6  decoded display value 0..99 (saturates at 63; see err_code).
- phase_done  out  1  one-cycle pulse on each legal phase change.
- err_onehot  out  1  sticky; lamp vector not exactly one-hot.
- err_code  out  1  sticky; illegal segment code, DP low, or value > 63.
- err_seq  out  1  sticky; illegal phase order, wrong entry value, or phase left at nonzero value.
- err_count  out  1  sticky; value changed other than by -1 within a phase.
- err_timing  out  1  sticky; a second was shorter or longer than TICK_CYCLES±TOL_CYCLES.
- err_any  out  1  OR of all err_* flags.

Behaviour:
- **Reset:** all outputs are 0 except phase=11. FSM=SYNC. Counters are 0.
- **Input stage:** all inputs registered once (stage S). Checks compare S against previous-sample registers P. Flags and status assert 2 clk after the input edge.
- **Decode:**
  - Each digit maps the active-low codes for 0..9 (0=1000000, 1=1111001, … 9=0010000).
  - Any other code sets err_code, and the value is held at the previous value.
  - DP bit = 0 sets err_code.
  - value = tens*10 + ones.
- **One-hot check:** evaluated every cycle. A lamp vector other than exactly one-hot sets err_onehot, and no phase or count checks run that cycle.
- **FSM states:** SYNC, RED, GREEN, YELLOW.
  - SYNC: only one-hot and code checks run. On the first change of the lamp vector to a valid one-hot value, enter the corresponding state. No entry-value or timing check is made on that first entry. sec_cnt resets to 0.
  - Phase state, lamp unchanged:
    - value == P value: no action.
    - value == P-1: legal tick. Run the timing check, then reset sec_cnt.
    - Any other value: set err_count and adopt the new value.
  - Phase state, lamp changed to the successor (RED→GREEN→YELLOW→RED):
    - Pulse phase_done.
    - Require P value == 0; otherwise set err_seq.
    - Require new value == start value of the new phase; otherwise set err_seq.
    - Run the timing check, reset sec_cnt, and enter the new state.
  - Phase state, lamp changed to a non-successor one-hot value: set err_seq, then follow the new lamp (no phase_done).
- **Timing:**
  - sec_cnt increments on en=1 cycles and saturates at 2^26-1.
  - Timing check: pass iff TICK_CYCLES-TOL_CYCLES ≤ sec_cnt+1 ≤ TICK_CYCLES+TOL_CYCLES.
  - Stall: if sec_cnt+1 exceeds TICK_CYCLES+TOL_CYCLES with no change, set err_timing once per second interval (no repeat until the next change).
- **Sticky flags:** set-dominant. If clr_err and a new error occur in the same cycle, the flag ends 1. clr_err does not affect the FSM.
- **Reset mid-operation:** returns to SYNC on the next edge. In-flight checks are discarded.

Decomposition:
- Package traffic_pkg:
  - phase enum (RED=2'b00, GREEN=2'b01, YELLOW=2'b10, plus NONE=2'b11 for monitor use).
  - Default phase durations.
  - Ten 7-bit active-low segment code constants and the blank code 7'b1111111.
- Sub-module seg7_digit_decode: combinational; 7-bit code in, 4-bit digit plus valid out; instantiated twice. The controller's encoder may reuse the package constants.

Test Plan (TICK_CYCLES=10, TOL_CYCLES=2):
1. **Full legal cycle:** drive a golden controller through RED 18→0, GREEN 15→0, YELLOW 3→0, RED. Expect: phase_done pulses 3 times after sync; every err_*=0; cur_value tracks the display with 2-clk latency.
2. **Short second:** one second lasts 7 cycles. Expect err_timing=1 two clk after the decrement; other flags 0.
3. **Skipped state / early exit:** go RED→YELLOW. Expect err_seq=1 and phase=10. Separately, leave GREEN at value 4: expect err_seq=1.
4. **Bad lamps and bad segments:** red+green both high for 1 cycle, and ones segments=7'b0110110. Expect err_onehot=1, err_code=1, and cur_value held.
5. **Count jump:** value goes 12→10 inside RED. Expect err_count=1. Then assert clr_err in the same cycle as a new jump: expect err_count stays 1. clr_err alone later: expect all flags 0.
6. **Stall and recovery:** hold en=0 for 50 cycles mid-second, so no err_timing. Then hold the value for 20 en cycles: expect a single err_timing. Assert rst mid-phase: expect phase=11 and all flags 0 next cycle.
